fir_ctrl: RTL and testbench
===========================

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameters SHALL be: pADDR_WIDTH, 12, RAM byte-address width; pDATA_WIDTH, 32, data/length width; Tape_Num, 11, tap count.
REQ-002 Ports SHALL be:
- axis_clk  in  1  single clock, rising edge.
- axis_rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse on an AXI-Lite write of 1 to 0x00 bit0.
- cfg_rd_ctrl  in  1  one-cycle pulse on an AXI-Lite read of 0x00.
- cfg_len  in  pDATA_WIDTH  sample count (register 0x10).
- ss_tvalid  in  1  input stream valid.
- ss_tlast  in  1  input stream last.
- ss_tready  out  1  input stream ready.
- sm_tvalid  out  1  output stream valid.
- sm_tready  in  1  output stream ready.
- sm_tlast  out  1  output stream last.
- tap_EN, tap_A  out  1, pADDR_WIDTH  tap RAM enable and byte address.
- data_EN, data_WE, data_A  out  1, 4, pADDR_WIDTH  data RAM enable, byte write enable and byte address.
- mac_clr, mac_en  out  1, 1  accumulator clear and accumulate strobes.
- ap_start, ap_done, ap_idle  out  1, 1, 1  status bits 0, 1, 2.
- cycle_count  out  32  performance counter.

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, WAIT_IN, MAC, DRAIN, OUT.
REQ-004 IDLE: cfg_start SHALL move to CLEAR; cfg_start in any other state SHALL be ignored.
REQ-005 CLEAR SHALL last Tape_Num cycles, writing zero to data words 0..Tape_Num-1 (data_WE=4'hF, data_A=4*i), with ap_start=1, then enter WAIT_IN and reset wptr and sample count to 0.
REQ-006 If cfg_len==0, CLEAR SHALL exit directly to IDLE with ap_done=1 and no stream traffic.
REQ-007 ss_tready SHALL be 1 only in WAIT_IN.
REQ-008 On handshake the block SHALL write the sample at data_A=4*wptr (data_WE=4'hF), pulse mac_clr, latch ss_tlast, and enter MAC.
REQ-009 MAC SHALL last Tape_Num cycles; cycle k (0..Tape_Num-1) SHALL drive tap_A=4*k and data_A=4*((wptr-k) mod Tape_Num) with data_WE=0.
REQ-010 mac_en SHALL assert one cycle after each MAC address to match one-cycle RAM read latency; DRAIN SHALL carry the final mac_en.
REQ-011 tap_EN and data_EN SHALL be 1 in CLEAR, WAIT_IN, MAC and DRAIN, and 0 otherwise.
REQ-012 After DRAIN the block SHALL enter OUT, in which sm_tvalid=1 is held until sm_tready.
REQ-013 On the OUT handshake: wptr SHALL wrap from Tape_Num-1 to 0, and the sample count SHALL increment.
REQ-014 The sample SHALL be final if the count reaches cfg_len or the latched tlast is 1, whichever comes first.
REQ-015 sm_tlast SHALL be 1 during OUT for the final sample.
REQ-016 After the final sample's OUT handshake the block SHALL go to IDLE; otherwise it SHALL return to WAIT_IN.
REQ-017 Per-sample latency with sm_tready=1 SHALL be Tape_Num+3 cycles (handshake to handshake).
REQ-018 ap_idle SHALL be 1 exactly in IDLE.
REQ-019 ap_done SHALL set on entry to IDLE from OUT or CLEAR, and clear on cfg_rd_ctrl or cfg_start; set SHALL win over a simultaneous cfg_rd_ctrl.
REQ-020 cfg_len SHALL be sampled on cfg_start; later changes SHALL not affect the current run.

Reset
REQ-021 While axis_rst_n=0, state SHALL be IDLE and counters and wptr SHALL be 0.
REQ-022 While axis_rst_n=0, all outputs SHALL be 0 except ap_idle=1.
REQ-023 Reset asserted mid-run SHALL abort the run immediately, with no sm_tvalid afterwards and ap_done=0.

Configuration
REQ-024 With FIR_CTRL_PERF_EN defined, cycle_count SHALL clear on accepted cfg_start, increment every non-IDLE cycle, and hold in IDLE.
REQ-025 Without FIR_CTRL_PERF_EN, cycle_count SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-026 cfg_len=4, always-valid input, sm_tready=1 -> 4 outputs 14 cycles apart, sm_tlast only on 4th, ap_done=1, ap_idle=1.
REQ-027 cfg_len=12 -> data_A MAC sequence on sample 12 starts at 4*0 (wptr wrapped) then 4*10, 4*9, ... 4*1.
REQ-028 cfg_len=8, ss_tlast on sample 3 -> exactly 3 outputs, sm_tlast on 3rd, ap_done=1.
REQ-029 sm_tready low for 5 cycles during OUT -> sm_tvalid held, sm_tdata path unchanged, no extra ss_tready.
REQ-030 cfg_start while busy plus cfg_rd_ctrl coincident with done -> start ignored and ap_done reads 1; a later read clears it.
REQ-031 axis_rst_n pulsed low mid-MAC -> immediate IDLE with ap_idle=1 and a clean subsequent run; with FIR_CTRL_PERF_EN, cfg_len=1 -> cycle_count=Tape_Num+Tape_Num+3.

Source files
------------

// File: rtl/fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_ctrl
// Purpose  : FIR sequencer - clears the data RAM, then per input sample walks
//            Tape_Num taps through the tap/data RAMs and hands the result out.
//            Define FIR_CTRL_PERF_EN to build the busy-cycle counter.
// Revision : 1.0
// ============================================================================
module fir_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   cfg_start,
    input  logic                   cfg_rd_ctrl,
    input  logic [pDATA_WIDTH-1:0] cfg_len,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic                   sm_tlast,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic                   mac_clr,
    output logic                   mac_en,
    output logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic [31:0]            cycle_count
);

    localparam int                     CNT_W    = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(Tape_Num - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
    localparam logic [pDATA_WIDTH-1:0] LEN_ONE  = pDATA_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        WAIT_IN = 3'd2,
        MAC     = 3'd3,
        DRAIN   = 3'd4,
        OUT     = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       wptr;
    logic [CNT_W-1:0]       ridx;
    logic [pDATA_WIDTH-1:0] len_q;
    logic [pDATA_WIDTH-1:0] sample_cnt;
    logic                   tlast_q;

    logic in_hs;
    logic out_hs;
    logic last_sample;
    logic clear_end;
    logic mac_end;
    logic done_set;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [CNT_W-1:0] idx);
        return pADDR_WIDTH'({idx, 2'b00});
    endfunction

    assign in_hs       = (state == WAIT_IN) && ss_tvalid;
    assign out_hs      = (state == OUT) && sm_tready;
    assign last_sample = tlast_q || ((sample_cnt + LEN_ONE) == len_q);
    assign clear_end   = (state == CLEAR) && (cnt == CNT_LAST);
    assign mac_end     = (state == MAC) && (cnt == CNT_LAST);
    assign done_set    = (out_hs && last_sample) || (clear_end && (len_q == '0));

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        tap_EN    = 1'b0;
        tap_A     = '0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        mac_clr   = 1'b0;
        ap_start  = 1'b0;
        ap_idle   = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (cfg_start) state_nx = CLEAR;
            end
            CLEAR: begin
                tap_EN   = 1'b1;
                data_EN  = 1'b1;
                data_WE  = 4'hF;
                data_A   = word_addr(cnt);
                ap_start = 1'b1;
                if (clear_end) state_nx = (len_q == '0) ? IDLE : WAIT_IN;
            end
            WAIT_IN: begin
                ss_tready = 1'b1;
                tap_EN    = 1'b1;
                data_EN   = 1'b1;
                data_A    = word_addr(wptr);
                if (ss_tvalid) begin
                    data_WE  = 4'hF;
                    mac_clr  = 1'b1;
                    state_nx = MAC;
                end
            end
            MAC: begin
                tap_EN  = 1'b1;
                data_EN = 1'b1;
                tap_A   = word_addr(cnt);
                data_A  = word_addr(ridx);
                if (mac_end) state_nx = DRAIN;
            end
            DRAIN: begin
                tap_EN   = 1'b1;
                data_EN  = 1'b1;
                state_nx = OUT;
            end
            OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = last_sample;
                if (sm_tready) state_nx = last_sample ? IDLE : WAIT_IN;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            cnt        <= '0;
            wptr       <= '0;
            ridx       <= '0;
            len_q      <= '0;
            sample_cnt <= '0;
            tlast_q    <= 1'b0;
            mac_en     <= 1'b0;
            ap_done    <= 1'b0;
        end else begin
            // RAM read data lags the address by one cycle, so the accumulate strobe does too
            mac_en <= (state == MAC);

            if (((state == CLEAR) && !clear_end) || ((state == MAC) && !mac_end))
                cnt <= cnt + CNT_ONE;
            else
                cnt <= '0;

            if ((state == IDLE) && cfg_start) len_q <= cfg_len;

            if (clear_end) begin
                wptr       <= '0;
                sample_cnt <= '0;
            end else if (out_hs) begin
                wptr       <= (wptr == CNT_LAST) ? '0 : wptr + CNT_ONE;
                sample_cnt <= sample_cnt + LEN_ONE;
            end

            // ridx walks backwards through the circular sample buffer, newest first
            if (in_hs) begin
                tlast_q <= ss_tlast;
                ridx    <= wptr;
            end else if (state == MAC) begin
                ridx <= (ridx == '0) ? CNT_LAST : ridx - CNT_ONE;
            end

            if (done_set)
                ap_done <= 1'b1;
            else if (cfg_rd_ctrl || cfg_start)
                ap_done <= 1'b0;
        end
    end

`ifdef FIR_CTRL_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n)
            perf_cnt <= 32'd0;
        else if ((state == IDLE) && cfg_start)
            perf_cnt <= 32'd0;
        else if (state != IDLE)
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign cycle_count = perf_cnt;
`else
    assign cycle_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_ctrl
// Purpose  : Directed/randomised frame runs of fir_ctrl against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_fir_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int N  = 11;

    logic          axis_clk    = 1'b0;
    logic          axis_rst_n  = 1'b0;
    logic          cfg_start   = 1'b0;
    logic          cfg_rd_ctrl = 1'b0;
    logic [DW-1:0] cfg_len     = '0;
    logic          ss_tvalid   = 1'b0;
    logic          ss_tlast    = 1'b0;
    logic          sm_tready   = 1'b0;
    logic          ss_tready;
    logic          sm_tvalid;
    logic          sm_tlast;
    logic          tap_EN;
    logic [AW-1:0] tap_A;
    logic          data_EN;
    logic [3:0]    data_WE;
    logic [AW-1:0] data_A;
    logic          mac_clr;
    logic          mac_en;
    logic          ap_start;
    logic          ap_done;
    logic          ap_idle;
    logic [31:0]   cycle_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fir_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(N)) dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .cfg_start   (cfg_start),
        .cfg_rd_ctrl (cfg_rd_ctrl),
        .cfg_len     (cfg_len),
        .ss_tvalid   (ss_tvalid),
        .ss_tlast    (ss_tlast),
        .ss_tready   (ss_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tready   (sm_tready),
        .sm_tlast    (sm_tlast),
        .tap_EN      (tap_EN),
        .tap_A       (tap_A),
        .data_EN     (data_EN),
        .data_WE     (data_WE),
        .data_A      (data_A),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .cycle_count (cycle_count)
    );

    always #5 axis_clk = ~axis_clk;
    always @(posedge axis_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rr: 0 = always ready, 1 = random ready, 2 = ready low for 5 OUT cycles
    task automatic run_frame(input int len, input int tl_at, input bit rv, input int rr,
                             input bit busy_start, input bit rd_on_done, input int abort_s);
        int n_exp;
        int busy;
        int prev_out;
        int waited;
        int exp_cc;
        bit fin;
        n_exp    = (tl_at != 0 && tl_at < len) ? tl_at : len;
        busy     = 0;
        prev_out = -1;

        @(negedge axis_clk);
        cfg_start = 1'b1; cfg_len = DW'(len); ss_tvalid = 1'b0; sm_tready = 1'b0;
        #1;
        chk("idle_before_start", ap_idle, 1);
        @(negedge axis_clk);
        cfg_start = 1'b0; cfg_len = $urandom;
        #1;
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin @(negedge axis_clk); #1; end
            busy++;
            chk("clr_we", data_WE, 4'hF);
            chk("clr_addr", data_A, 4 * i);
            chk("clr_ap_start", ap_start, 1);
            chk("clr_en", {tap_EN, data_EN, ap_idle, ap_done}, 4'b1100);
        end

        for (int s = 0; s < n_exp; s++) begin
            waited = 0;
            forever begin
                @(negedge axis_clk);
                ss_tvalid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
                ss_tlast  = (s + 1 == tl_at);
                sm_tready = 1'($urandom_range(0, 1));
                #1;
                busy++;
                chk("in_ready", ss_tready, 1);
                chk("in_mac_clr", mac_clr, ss_tvalid);
                if (ss_tvalid) break;
                waited++;
                if (waited > 40) begin chk("in_timeout", waited, 0); return; end
            end
            chk("in_we", data_WE, 4'hF);
            chk("in_addr", data_A, 4 * (s % N));

            for (int k = 0; k < N; k++) begin
                @(negedge axis_clk);
                ss_tvalid = 1'($urandom_range(0, 1));
                ss_tlast  = 1'($urandom_range(0, 1));
                cfg_start = busy_start && (s == 0) && (k == 2);
                #1;
                busy++;
                chk("mac_tap_addr", tap_A, 4 * k);
                chk("mac_data_addr", data_A, 4 * (((s - k) % N + N) % N));
                chk("mac_ctl", {data_WE, ss_tready, sm_tvalid, tap_EN, data_EN}, 8'b0000_0011);
                chk("mac_en", mac_en, (k > 0));
                if (abort_s == s && k == 4) begin
                    #1 axis_rst_n = 1'b0;
                    #1;
                    chk("rst_idle", ap_idle, 1);
                    chk("rst_outs", {ss_tready, sm_tvalid, tap_EN, data_EN, mac_en, ap_done, ap_start}, 7'b0);
                    chk("rst_cycle_count", cycle_count, 0);
                    @(negedge axis_clk);
                    cfg_start = 1'b0; ss_tvalid = 1'b0; ss_tlast = 1'b0;
                    #1;
                    chk("rst_hold", {ap_idle, sm_tvalid, ss_tready}, 3'b100);
                    axis_rst_n = 1'b1;
                    return;
                end
            end

            @(negedge axis_clk);
            ss_tvalid = 1'b0; cfg_start = 1'b0;
            #1;
            busy++;
            chk("drain_mac_en", mac_en, 1);
            chk("drain_ctl", {sm_tvalid, ss_tready, tap_EN}, 3'b001);

            fin    = (s + 1 == n_exp);
            waited = 0;
            forever begin
                @(negedge axis_clk);
                case (rr)
                    0:       sm_tready = 1'b1;
                    1:       sm_tready = 1'($urandom_range(0, 1));
                    default: sm_tready = (waited >= 5);
                endcase
                ss_tvalid   = 1'($urandom_range(0, 1));
                cfg_rd_ctrl = rd_on_done && fin && sm_tready;
                #1;
                busy++;
                chk("out_valid", sm_tvalid, 1);
                chk("out_last", sm_tlast, fin);
                chk("out_no_in_ready", {ss_tready, tap_EN}, 2'b00);
                if (sm_tready) break;
                waited++;
                if (waited > 40) begin chk("out_timeout", waited, 0); return; end
            end
            if (!rv && rr == 0 && prev_out >= 0) chk("out_spacing", cyc - prev_out, N + 3);
            prev_out = cyc;
        end

        @(negedge axis_clk);
        cfg_rd_ctrl = 1'b0; sm_tready = 1'b0; ss_tvalid = 1'b0; ss_tlast = 1'b0;
        #1;
        chk("end_idle", ap_idle, 1);
        chk("end_done", ap_done, 1);
        chk("end_quiet", {sm_tvalid, ss_tready}, 2'b00);
        exp_cc = (!rv && rr == 0) ? N + n_exp * (N + 3) : busy;
`ifdef FIR_CTRL_PERF_EN
        chk("perf_count", cycle_count, exp_cc);
`else
        chk("perf_off", cycle_count, 0);
`endif
    endtask

    initial begin
        int len;
        ss_tvalid = 1'b1;
        repeat (2) @(negedge axis_clk);
        #1;
        chk("reset_idle", ap_idle, 1);
        chk("reset_outs", {ss_tready, sm_tvalid, sm_tlast, tap_EN, data_EN, data_WE,
                           mac_clr, mac_en, ap_start, ap_done}, 13'b0);
        chk("reset_addr", {tap_A, data_A}, 24'b0);
        chk("reset_cycle_count", cycle_count, 0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1; ss_tvalid = 1'b0;

        run_frame(4, 0, 1'b0, 0, 1'b0, 1'b0, -1);
        run_frame(12, 0, 1'b0, 0, 1'b0, 1'b0, -1);
        run_frame(8, 3, 1'b0, 0, 1'b0, 1'b0, -1);
        run_frame(3, 0, 1'b0, 2, 1'b0, 1'b0, -1);

        run_frame(2, 0, 1'b0, 0, 1'b1, 1'b1, -1);
        @(negedge axis_clk);
        cfg_rd_ctrl = 1'b1;
        #1;
        chk("rd_done_still_set", ap_done, 1);
        @(negedge axis_clk);
        cfg_rd_ctrl = 1'b0;
        #1;
        chk("rd_done_cleared", ap_done, 0);

        run_frame(0, 0, 1'b0, 0, 1'b0, 1'b0, -1);
        run_frame(6, 0, 1'b0, 0, 1'b0, 1'b0, 1);
        run_frame(1, 0, 1'b0, 0, 1'b0, 1'b0, -1);

        for (int f = 0; f < 3; f++) begin
            len = int'($urandom_range(1, 14));
            run_frame(len, int'($urandom_range(0, len)), 1'b1, 1, 1'b0, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
